lc3_sram_responder: RTL



---
 rtl/lc3_sram_responder.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/lc3_sram_responder.sv
// lc3_sram_responder
//   Cycle-level behavioural model of the asynchronous SRAM behind the LC-3
//   control unit. It answers read and write strobes after a fixed latency,
//   keeps its own word array (preloadable from a side port), and raises a
//   sticky flag on bus protocol violations.
//
// Ports
//   Clk, Reset         clock, synchronous active-high reset
//   Mem_CE/UB/LB/OE/WE active-low SRAM strobes from the control unit
//   ADDR               word address (bits above log2(DEPTH) ignored)
//   Data_to_SRAM       write data
//   Data_from_SRAM     registered read data, 16'h0000 when not valid
//   Data_valid         Data_from_SRAM holds array contents for current ADDR
//   Init_we/addr/data  preload port, honoured only while CE is high
//   Conflict           sticky violation flag, cleared only by Reset
module lc3_sram_responder #(
  parameter int ADDR_WIDTH = 20,
  parameter int DEPTH      = 256,
  parameter int READ_LAT   = 1,
  parameter int WRITE_LAT  = 1,
  localparam int IDX_W     = $clog2(DEPTH)
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Mem_CE,
  input  logic                  Mem_UB,
  input  logic                  Mem_LB,
  input  logic                  Mem_OE,
  input  logic                  Mem_WE,
  input  logic [ADDR_WIDTH-1:0] ADDR,
  input  logic [15:0]           Data_to_SRAM,
  output logic [15:0]           Data_from_SRAM,
  output logic                  Data_valid,
  input  logic                  Init_we,
  input  logic [IDX_W-1:0]      Init_addr,
  input  logic [15:0]           Init_data,
  output logic                  Conflict
);

  typedef enum logic [2:0] {
    IDLE,
    READ_WAIT,
    READ_DRIVE,
    WRITE_WAIT,
    WRITE_DONE
  } state_t;

  localparam logic [2:0] RD_LAT = 3'(READ_LAT);
  localparam logic [2:0] WR_LAT = 3'(WRITE_LAT);

  // Read path: byte lanes whose enable is high read back as zero.
  function automatic logic [15:0] lane_gate(input logic [15:0] word,
                                            input logic        ub_n,
                                            input logic        lb_n);
    lane_gate = {ub_n ? 8'h00 : word[15:8], lb_n ? 8'h00 : word[7:0]};
  endfunction

  // Write path: disabled lanes keep their previous contents.
  function automatic logic [15:0] lane_merge(input logic [15:0] old_word,
                                             input logic [15:0] new_word,
                                             input logic        ub_n,
                                             input logic        lb_n);
    lane_merge = {ub_n ? old_word[15:8] : new_word[15:8],
                  lb_n ? old_word[7:0]  : new_word[7:0]};
  endfunction

  logic [15:0]      mem [DEPTH];

  state_t           state, state_nxt;
  logic [2:0]       cnt, cnt_nxt, cnt_inc;
  logic [IDX_W-1:0] addr_lat, addr_nxt;
  logic [IDX_W-1:0] idx;
  logic             addr_same;
  logic             rd, wr, clash, init_ok, init_bad;
  logic             commit;
  logic [15:0]      rd_word, wr_word;
  logic [15:0]      data_nxt, data_p1;
  logic             vld_nxt, vld_p1;
  logic             conflict, conflict_nxt;

  assign idx = ADDR[IDX_W-1:0];

  generate
    if (ADDR_WIDTH > IDX_W) begin : g_addr_hi
      // Upper address bits alias onto the array; they are deliberately unused.
      logic unused_addr_hi;
      assign unused_addr_hi = ^ADDR[ADDR_WIDTH-1:IDX_W];
    end
  endgenerate

  assign rd       = ~Mem_CE & ~Mem_OE & Mem_WE;
  assign wr       = ~Mem_CE & ~Mem_WE;
  assign clash    = ~Mem_CE & ~Mem_OE & ~Mem_WE;
  assign init_ok  = Init_we & Mem_CE;
  assign init_bad = Init_we & ~Mem_CE;

  assign addr_same = (idx == addr_lat);
  assign rd_word   = lane_gate(mem[idx], Mem_UB, Mem_LB);
  assign wr_word   = lane_merge(mem[idx], Data_to_SRAM, Mem_UB, Mem_LB);

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    addr_nxt     = addr_lat;
    data_nxt     = 16'h0000;
    vld_nxt      = 1'b0;
    commit       = 1'b0;
    conflict_nxt = conflict | clash | init_bad;
    cnt_inc      = (cnt == 3'd7) ? cnt : cnt + 3'd1;

    case (state)
      IDLE, READ_WAIT, READ_DRIVE: begin
        if (wr) begin
          // A write strobe always wins; any read in progress is dropped.
          addr_nxt = idx;
          cnt_nxt  = 3'd1;
          if (WR_LAT <= 3'd1) begin
            commit    = 1'b1;
            state_nxt = WRITE_DONE;
          end else begin
            state_nxt = WRITE_WAIT;
          end
        end else if (rd) begin
          if (state == IDLE || !addr_same) begin
            // Fresh read or address moved: count restarts at this edge.
            addr_nxt = idx;
            cnt_nxt  = 3'd1;
            if (RD_LAT <= 3'd1) begin
              state_nxt = READ_DRIVE;
              vld_nxt   = 1'b1;
              data_nxt  = rd_word;
            end else begin
              state_nxt = READ_WAIT;
            end
          end else if (state == READ_WAIT) begin
            cnt_nxt = cnt_inc;
            if (cnt_inc >= RD_LAT) begin
              state_nxt = READ_DRIVE;
              vld_nxt   = 1'b1;
              data_nxt  = rd_word;
            end
          end else begin
            vld_nxt  = 1'b1;
            data_nxt = rd_word;
          end
        end else begin
          state_nxt = IDLE;
          cnt_nxt   = 3'd0;
        end
      end

      WRITE_WAIT: begin
        if (!wr) begin
          state_nxt = IDLE;
          cnt_nxt   = 3'd0;
        end else if (!addr_same) begin
          addr_nxt = idx;
          cnt_nxt  = 3'd1;
          if (WR_LAT <= 3'd1) begin
            commit    = 1'b1;
            state_nxt = WRITE_DONE;
          end
        end else begin
          cnt_nxt = cnt_inc;
          if (cnt_inc >= WR_LAT) begin
            commit    = 1'b1;
            state_nxt = WRITE_DONE;
          end
        end
      end

      WRITE_DONE: begin
        // One commit per WE-low pulse; wait here until the strobe releases.
        if (!wr) begin
          state_nxt = IDLE;
          cnt_nxt   = 3'd0;
        end
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 3'd0;
      end
    endcase
  end

  // ---- stage p1: control state and registered read port ----
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      cnt      <= 3'd0;
      data_p1  <= 16'h0000;
      vld_p1   <= 1'b0;
      conflict <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      data_p1  <= data_nxt;
      vld_p1   <= vld_nxt;
      conflict <= conflict_nxt;
    end
  end

  always_ff @(posedge Clk) begin
    addr_lat <= addr_nxt;
  end

  // Array storage is never cleared. Commit needs CE low and preload needs
  // CE high, so the two write sources can never collide.
  always_ff @(posedge Clk) begin
    if (commit && !Reset) begin
      mem[idx] <= wr_word;
    end else if (init_ok) begin
      mem[Init_addr] <= Init_data;
    end
  end

  assign Data_from_SRAM = data_p1;
  assign Data_valid     = vld_p1;
  assign Conflict       = conflict;

endmodule
